// File: rtl/acc_sequencer.sv
// Program sequencer for the accumulator/ALU block: fetches 8-bit instructions from a
// synchronous-read ROM, issues one-cycle accumulator strobes and resolves carry jumps.
module acc_sequencer #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] prog_addr,
   input  logic [7:0]        prog_data,
   input  logic [7:0]        ext_in,
   input  logic              carry_in,
   input  logic              start,
   output logic [2:0]        operation_code,
   output logic              aku_enable,
   output logic [7:0]        in_b,
   output logic              carry_flag,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_OPER, S_EXEC, S_HALT
   } state_t;

   localparam logic [1:0] K_IMM = 2'b00;
   localparam logic [1:0] K_REG = 2'b01;
   localparam logic [1:0] K_JMP = 2'b10;
   localparam logic [1:0] K_CTL = 2'b11;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [7:0]        opnd_q, opnd_d;
   logic              carry_q, carry_d;
   logic              jmp_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         opnd_q  <= '0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         opnd_q  <= opnd_d;
         carry_q <= carry_d;
      end
   end

   // Jumps only consult the carry captured by the latest EXEC; they never write it.
   assign jmp_taken = !ir_q[0] || carry_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      opnd_d  = opnd_q;
      carry_d = carry_q;
      case (state_q)
         S_FETCH: begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d = prog_data;
            case (prog_data[4:3])
               K_IMM, K_JMP: begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = S_OPER;
               end
               K_REG:   state_d = S_EXEC;
               K_CTL:   state_d = prog_data[0] ? S_HALT : S_FETCH;
               default: state_d = S_FETCH;
            endcase
         end
         S_OPER: begin
            opnd_d = prog_data;
            if (ir_q[4:3] == K_JMP) begin
               if (jmp_taken) pc_d = ADDR_W'(prog_data);
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            carry_d = carry_in;
            state_d = S_FETCH;
         end
         S_HALT: begin
            if (start) begin
               pc_d    = '0;
               carry_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   // Strobe is decoded from state so an async reset drops it without a clock edge.
   always_comb begin
      prog_addr      = pc_q;
      operation_code = ir_q[7:5];
      aku_enable     = (state_q == S_EXEC);
      halted         = (state_q == S_HALT);
      carry_flag     = carry_q;
      in_b           = (ir_q[4:3] == K_IMM) ? opnd_q : ext_in;
   end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed bench for acc_sequencer: a registered-read ROM model feeds the DUT, outputs
// are sampled on the falling edge and compared against hand-derived values.
module tb_acc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] prog_addr;
   logic [7:0] prog_data = 8'h00;
   logic [7:0] ext_in = 8'h00;
   logic       carry_in = 1'b0;
   logic       start = 1'b0;
   logic [2:0] operation_code;
   logic       aku_enable;
   logic [7:0] in_b;
   logic       carry_flag;
   logic       halted;

   logic [7:0] rom [256];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) prog_data <= rom[prog_addr];

   acc_sequencer #(.ADDR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .prog_addr(prog_addr), .prog_data(prog_data),
      .ext_in(ext_in), .carry_in(carry_in), .start(start),
      .operation_code(operation_code), .aku_enable(aku_enable), .in_b(in_b),
      .carry_flag(carry_flag), .halted(halted)
   );

   task automatic fill_halt();
      for (int i = 0; i < 256; i++) rom[i] = 8'h19;
   endtask

   // Leaves the bench on a falling edge with no rising edge since release.
   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      fill_halt();
      rom[0] = 8'h00; rom[1] = 8'h0A;
      start = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      tests++; if (halted !== 1'b0 || prog_addr !== 8'h00) begin fails++;
         $display("FAIL reset_with_start halted=%b addr=%0h want 0/00", halted, prog_addr); end
      start = 1'b0;
      do_reset();
      tests++; if (prog_addr !== 8'h00 || aku_enable !== 1'b0 || halted !== 1'b0 ||
                   carry_flag !== 1'b0 || operation_code !== 3'd0) begin fails++;
         $display("FAIL reset_state addr=%0h aku=%b halt=%b cf=%b op=%0d want 0/0/0/0/0",
                  prog_addr, aku_enable, halted, carry_flag, operation_code); end
   endtask

   task automatic test_alu_imm();
      cyc(1);
      tests++; if (prog_addr !== 8'h01 || aku_enable !== 1'b0) begin fails++;
         $display("FAIL imm_decode addr=%0h aku=%b want 01/0", prog_addr, aku_enable); end
      cyc(1);
      tests++; if (prog_addr !== 8'h02 || aku_enable !== 1'b0) begin fails++;
         $display("FAIL imm_oper addr=%0h aku=%b want 02/0", prog_addr, aku_enable); end
      cyc(1);
      tests++; if (aku_enable !== 1'b1 || operation_code !== 3'd0 || in_b !== 8'h0A) begin fails++;
         $display("FAIL imm_exec aku=%b op=%0d in_b=%0h want 1/0/0a", aku_enable, operation_code, in_b); end
      cyc(1);
      tests++; if (prog_addr !== 8'h02 || aku_enable !== 1'b0) begin fails++;
         $display("FAIL imm_next addr=%0h aku=%b want 02/0", prog_addr, aku_enable); end
   endtask

   task automatic test_alu_reg();
      fill_halt();
      rom[0] = 8'hC8;
      ext_in = 8'h5A; carry_in = 1'b1;
      do_reset();
      cyc(1);
      tests++; if (aku_enable !== 1'b0) begin fails++;
         $display("FAIL reg_decode aku=%b want 0", aku_enable); end
      cyc(1);
      tests++; if (aku_enable !== 1'b1 || operation_code !== 3'd6 || in_b !== 8'h5A ||
                   carry_flag !== 1'b0) begin fails++;
         $display("FAIL reg_exec aku=%b op=%0d in_b=%0h cf=%b want 1/6/5a/0",
                  aku_enable, operation_code, in_b, carry_flag); end
      cyc(1);
      tests++; if (aku_enable !== 1'b0 || carry_flag !== 1'b1 || prog_addr !== 8'h01 ||
                   operation_code !== 3'd6) begin fails++;
         $display("FAIL reg_after aku=%b cf=%b addr=%0h op=%0d want 0/1/01/6",
                  aku_enable, carry_flag, prog_addr, operation_code); end
   endtask

   task automatic test_jumps();
      fill_halt();
      rom[0] = 8'hC8; rom[1] = 8'h11; rom[2] = 8'h20;
      carry_in = 1'b1;
      do_reset();
      cyc(6);
      tests++; if (prog_addr !== 8'h20 || carry_flag !== 1'b1) begin fails++;
         $display("FAIL jc_taken addr=%0h cf=%b want 20/1", prog_addr, carry_flag); end
      carry_in = 1'b0;
      do_reset();
      cyc(6);
      tests++; if (prog_addr !== 8'h03 || carry_flag !== 1'b0) begin fails++;
         $display("FAIL jc_not_taken addr=%0h cf=%b want 03/0", prog_addr, carry_flag); end
      fill_halt();
      rom[0] = 8'h10; rom[1] = 8'h05;
      do_reset();
      cyc(3);
      tests++; if (prog_addr !== 8'h05) begin fails++;
         $display("FAIL jmp_uncond addr=%0h want 05", prog_addr); end
      fill_halt();
      rom[4] = 8'h10; rom[5] = 8'h04; rom[0] = 8'h10; rom[1] = 8'h04;
      do_reset();
      cyc(6);
      tests++; if (prog_addr !== 8'h04 || halted !== 1'b0) begin fails++;
         $display("FAIL jmp_self_1 addr=%0h halt=%b want 04/0", prog_addr, halted); end
      cyc(9);
      tests++; if (prog_addr !== 8'h04 || halted !== 1'b0) begin fails++;
         $display("FAIL jmp_self_4 addr=%0h halt=%b want 04/0", prog_addr, halted); end
   endtask

   task automatic test_nop_halt();
      int bad;
      fill_halt();
      rom[0] = 8'hC8; rom[1] = 8'h18; rom[2] = 8'h19;
      carry_in = 1'b1;
      do_reset();
      cyc(3);
      tests++; if (prog_addr !== 8'h01 || carry_flag !== 1'b1) begin fails++;
         $display("FAIL nh_setup addr=%0h cf=%b want 01/1", prog_addr, carry_flag); end
      cyc(2);
      tests++; if (prog_addr !== 8'h02 || halted !== 1'b0) begin fails++;
         $display("FAIL nop_cycles addr=%0h halt=%b want 02/0", prog_addr, halted); end
      cyc(1);
      tests++; if (halted !== 1'b0 || prog_addr !== 8'h03) begin fails++;
         $display("FAIL halt_decode halt=%b addr=%0h want 0/03", halted, prog_addr); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (halted !== 1'b1 || aku_enable !== 1'b0 || prog_addr !== 8'h03) bad++;
      end
      tests++; if (bad !== 0) begin fails++;
         $display("FAIL halt_hold bad_cycles=%0d want 0 (halt=%b aku=%b addr=%0h)",
                  bad, halted, aku_enable, prog_addr); end
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      tests++; if (prog_addr !== 8'h00 || halted !== 1'b0 || carry_flag !== 1'b0) begin fails++;
         $display("FAIL start_restart addr=%0h halt=%b cf=%b want 00/0/0",
                  prog_addr, halted, carry_flag); end
      start = 1'b1;
      cyc(2);
      start = 1'b0;
      tests++; if (prog_addr !== 8'h01 || aku_enable !== 1'b1) begin fails++;
         $display("FAIL start_ignored addr=%0h aku=%b want 01/1", prog_addr, aku_enable); end
   endtask

   task automatic test_wrap();
      fill_halt();
      rom[0] = 8'h33; rom[1] = 8'h00; rom[2] = 8'h10; rom[3] = 8'hFF; rom[8'hFF] = 8'h60;
      carry_in = 1'b0;
      do_reset();
      cyc(3);
      tests++; if (prog_addr !== 8'h02) begin fails++;
         $display("FAIL wrap_jc_skip addr=%0h want 02", prog_addr); end
      cyc(3);
      tests++; if (prog_addr !== 8'hFF) begin fails++;
         $display("FAIL wrap_jump addr=%0h want ff", prog_addr); end
      cyc(1);
      tests++; if (prog_addr !== 8'h00) begin fails++;
         $display("FAIL wrap_pc addr=%0h want 00", prog_addr); end
      cyc(2);
      tests++; if (aku_enable !== 1'b1 || in_b !== 8'h33 || operation_code !== 3'd3) begin fails++;
         $display("FAIL wrap_exec aku=%b in_b=%0h op=%0d want 1/33/3", aku_enable, in_b, operation_code); end
      cyc(1);
      tests++; if (prog_addr !== 8'h01 || aku_enable !== 1'b0) begin fails++;
         $display("FAIL wrap_next addr=%0h aku=%b want 01/0", prog_addr, aku_enable); end
   endtask

   task automatic test_async_reset();
      fill_halt();
      rom[0] = 8'hC8; rom[1] = 8'hC8;
      carry_in = 1'b1;
      do_reset();
      cyc(5);
      tests++; if (aku_enable !== 1'b1 || carry_flag !== 1'b1) begin fails++;
         $display("FAIL ar_pre aku=%b cf=%b want 1/1", aku_enable, carry_flag); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (aku_enable !== 1'b0 || prog_addr !== 8'h00 || carry_flag !== 1'b0) begin fails++;
         $display("FAIL ar_immediate aku=%b addr=%0h cf=%b want 0/00/0", aku_enable, prog_addr, carry_flag); end
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1);
      tests++; if (prog_addr !== 8'h01 || aku_enable !== 1'b0) begin fails++;
         $display("FAIL ar_restart addr=%0h aku=%b want 01/0", prog_addr, aku_enable); end
      cyc(1);
      tests++; if (aku_enable !== 1'b1 || in_b !== 8'h5A) begin fails++;
         $display("FAIL ar_reexec aku=%b in_b=%0h want 1/5a", aku_enable, in_b); end
   endtask

   initial begin
      test_reset();
      test_alu_imm();
      test_alu_reg();
      test_jumps();
      test_nop_halt();
      test_wrap();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
